// File: rtl/uart_msg_tx.sv
// uart_msg_tx: buffered UART message transmitter with RTS flow control.
// Define UART_MSG_TX_PARITY_EN to add an even-parity bit to each frame.
module uart_msg_tx #(
    parameter int CLK_HZ    = 50000000,
    parameter int BAUD      = 9600,
    parameter int DEPTH     = 32,
    parameter int STOP_BITS = 1,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic [AW:0]   msg_len,
    input  logic          start,
    input  logic          repeat_en,
    input  logic          rts_n,
    output logic          txd,
    output logic          busy,
    output logic          done,
    output logic          byte_strobe
);

    localparam int DIV = CLK_HZ / BAUD;
    localparam int CW  = (DIV > 2) ? $clog2(DIV) : 1;

    localparam logic [CW-1:0] CNT_END  = CW'(DIV - 1);
    localparam logic [2:0]    STOP_END = 3'(STOP_BITS - 1);
    localparam logic [AW:0]   LEN_MAX  = (AW+1)'(DEPTH);
    localparam logic [AW:0]   IDX_ONE  = (AW+1)'(1);

`ifdef UART_MSG_TX_PARITY_EN
    typedef enum logic [2:0] {
        IDLE, WAIT_RTS, START, DATA,
        PARITY, STOP, NEXT
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE, WAIT_RTS, START, DATA,
        STOP, NEXT
    } state_t;
`endif

    state_t state_q, state_d;

    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    sh_q, sh_d;
    logic [AW:0]   idx_q, idx_d;
    logic [AW:0]   len_q, len_d;
    logic          rep_q, rep_d;
    logic          done_q, done_d;
    logic          stb_q, stb_d;
    logic          txd_q, txd_d;
`ifdef UART_MSG_TX_PARITY_EN
    logic          par_q, par_d;
`endif

    logic [7:0]  mem [DEPTH];
    logic [7:0]  rd_byte;
    logic [AW:0] len_in;
    logic [AW:0] idx_nx;
    logic        bit_end;
    logic        more;
    logic        again;
    logic        fin;

    // Buffer is writable at all times and never cleared by reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_byte = mem[idx_q[AW-1:0]];
    assign len_in  = (msg_len > LEN_MAX) ? LEN_MAX : msg_len;
    assign idx_nx  = idx_q + IDX_ONE;
    assign bit_end = (cnt_q == CNT_END);
    assign more    = (idx_nx < len_q);
    assign again   = !more && rep_q && repeat_en;
    assign fin     = !more && !again;

    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        bit_d   = bit_q;
        sh_d    = sh_q;
        idx_d   = idx_q;
        len_d   = len_q;
        rep_d   = rep_q;
        done_d  = 1'b0;
        stb_d   = 1'b0;
`ifdef UART_MSG_TX_PARITY_EN
        par_d   = par_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (start && msg_len != '0) begin
                    len_d   = len_in;
                    rep_d   = repeat_en;
                    idx_d   = '0;
                    state_d = WAIT_RTS;
                end
            end
            WAIT_RTS: begin
                if (!rts_n) begin
                    sh_d    = rd_byte;
`ifdef UART_MSG_TX_PARITY_EN
                    par_d   = ^rd_byte;
`endif
                    stb_d   = 1'b1;
                    state_d = START;
                end
            end
            START: begin
                cnt_d = bit_end ? '0 : cnt_q + CW'(1);
                if (bit_end) begin
                    bit_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                cnt_d = bit_end ? '0 : cnt_q + CW'(1);
                if (bit_end) begin
                    if (bit_q == 3'd7) begin
                        bit_d   = '0;
`ifdef UART_MSG_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        bit_d = bit_q + 3'd1;
                        sh_d  = {1'b0, sh_q[7:1]};
                    end
                end
            end
`ifdef UART_MSG_TX_PARITY_EN
            PARITY: begin
                cnt_d = bit_end ? '0 : cnt_q + CW'(1);
                if (bit_end) begin
                    bit_d   = '0;
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                cnt_d = bit_end ? '0 : cnt_q + CW'(1);
                if (bit_end) begin
                    if (bit_q == STOP_END) begin
                        bit_d   = '0;
                        state_d = NEXT;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            NEXT: begin
                unique case (1'b1)
                    more: begin
                        idx_d   = idx_nx;
                        state_d = WAIT_RTS;
                    end
                    again: begin
                        idx_d   = '0;
                        state_d = WAIT_RTS;
                    end
                    fin: begin
                        idx_d   = '0;
                        done_d  = 1'b1;
                        state_d = IDLE;
                    end
                    default: state_d = IDLE;
                endcase
            end
            default: state_d = IDLE;
        endcase
    end

    // Line level follows the state being entered, so txd is a clean flop
    always_comb begin
        txd_d = 1'b1;
        unique case (state_d)
            START:   txd_d = 1'b0;
            DATA:    txd_d = sh_d[0];
`ifdef UART_MSG_TX_PARITY_EN
            PARITY:  txd_d = par_q;
`endif
            default: txd_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            sh_q    <= '0;
            idx_q   <= '0;
            len_q   <= '0;
            rep_q   <= 1'b0;
            done_q  <= 1'b0;
            stb_q   <= 1'b0;
            txd_q   <= 1'b1;
`ifdef UART_MSG_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            sh_q    <= sh_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            rep_q   <= rep_d;
            done_q  <= done_d;
            stb_q   <= stb_d;
            txd_q   <= txd_d;
`ifdef UART_MSG_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign txd         = txd_q;
    assign busy        = (state_q != IDLE);
    assign done        = done_q;
    assign byte_strobe = stb_q;

endmodule

// File: tb/tb_uart_msg_tx.sv
// tb_uart_msg_tx: randomized and directed checks of uart_msg_tx
// against a bit-sampling UART receiver model and a buffer model.
`timescale 1ns/1ps
module tb_uart_msg_tx;

    localparam int CLK_HZ    = 1000;
    localparam int BAUD      = 100;
    localparam int DEPTH     = 8;
    localparam int STOP_BITS = 1;
    localparam int DIV       = CLK_HZ / BAUD;
`ifdef UART_MSG_TX_PARITY_EN
    localparam int NPAR = 1;
`else
    localparam int NPAR = 0;
`endif
    localparam int FB  = 1 + 8 + NPAR + STOP_BITS;
    localparam int FRM = FB * DIV;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0;
    logic [2:0] wr_addr = '0;
    logic [7:0] wr_data = '0;
    logic [3:0] msg_len = '0;
    logic       start = 1'b0;
    logic       repeat_en = 1'b0;
    logic       rts_n = 1'b1;
    logic       txd;
    logic       busy;
    logic       done;
    logic       byte_strobe;

    int n_chk = 0;
    int n_fail = 0;
    int rx_cnt = 0;
    int rx_start = 0;
    int exp_len = 1;
    int done_cnt = 0;
    int stb_cnt = 0;
    logic [7:0] mdl [DEPTH];

    uart_msg_tx #(
        .CLK_HZ(CLK_HZ),
        .BAUD(BAUD),
        .DEPTH(DEPTH),
        .STOP_BITS(STOP_BITS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .wr_en(wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .msg_len(msg_len),
        .start(start),
        .repeat_en(repeat_en),
        .rts_n(rts_n),
        .txd(txd),
        .busy(busy),
        .done(done),
        .byte_strobe(byte_strobe)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (done) done_cnt++;
        if (byte_strobe) stb_cnt++;
    end

    task automatic skip(input int n, output bit hit);
        hit = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (rst) begin
                hit = 1'b1;
                break;
            end
        end
    endtask

    // Receiver model: detect start edge, sample each bit mid-period
    initial begin : mon
        bit hit;
        logic [FB-1:0] f;
        logic [7:0] d;
        int stop_ok;
        forever begin
            @(negedge clk);
            if (!rst && txd === 1'b0) begin
                chk("strobe_at_start", int'(byte_strobe), 1);
                skip(DIV / 2, hit);
                f[0] = txd;
                for (int k = 1; k < FB && !hit; k++) begin
                    skip(DIV, hit);
                    f[k] = txd;
                end
                if (!hit) begin
                    d = f[8:1];
                    chk("start_bit", int'(f[0]), 0);
                    chk("rx_byte", int'(d),
                        int'(mdl[(rx_cnt - rx_start) % exp_len]));
`ifdef UART_MSG_TX_PARITY_EN
                    chk("parity", int'(f[9]), $countones(d) % 2);
`endif
                    stop_ok = 1;
                    for (int s = FB - STOP_BITS; s < FB; s++)
                        if (f[s] !== 1'b1) stop_ok = 0;
                    chk("stop_bits", stop_ok, 1);
                    rx_cnt++;
                end
            end
        end
    end

    task automatic wr(input int a, input logic [7:0] d);
        wr_en = 1'b1;
        wr_addr = 3'(a);
        wr_data = d;
        mdl[a] = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic go(input int len, input bit rep);
        rx_start = rx_cnt;
        if (len != 0) exp_len = (len > DEPTH) ? DEPTH : len;
        msg_len = 4'(len);
        repeat_en = rep;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int lim, input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < lim && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        chk(tag, int'(seen), 1);
    endtask

    task automatic wait_stb(input int lim, input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < lim && !seen; i++) begin
            @(negedge clk);
            if (byte_strobe) seen = 1'b1;
        end
        chk(tag, int'(seen), 1);
    endtask

    task automatic wait_rx(input int tgt, input int lim, input string tag);
        bit seen = (rx_cnt >= tgt);
        for (int i = 0; i < lim && !seen; i++) begin
            @(negedge clk);
            if (rx_cnt >= tgt) seen = 1'b1;
        end
        chk(tag, int'(seen), 1);
    endtask

    initial begin : main
        logic [15:0] fb;
        logic [7:0]  x;
        int err, s0, d0, r0, len, st;

        for (int i = 0; i < DEPTH; i++) mdl[i] = '0;
        repeat (3) @(negedge clk);
        chk("rst_txd", int'(txd), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_stb", int'(byte_strobe), 0);
        rst = 1'b0;
        @(negedge clk);

        // Single byte 0x48: exact waveform and done latency
        wr(0, 8'h48);
        x = 8'h48;
        fb = '1;
        fb[0] = 1'b0;
        for (int i = 0; i < 8; i++) fb[1+i] = x[i];
        if (NPAR != 0) fb[9] = ^x;
        rts_n = 1'b0;
        go(1, 1'b0);
        chk("busy_rise", int'(busy), 1);
        chk("wait_txd", int'(txd), 1);
        @(negedge clk);
        chk("first_low", int'(txd), 0);
        err = 0;
        for (int c = 0; c < FRM; c++) begin
            if (txd !== fb[c / DIV]) err++;
            @(negedge clk);
        end
        chk("frame_wave", err, 0);
        chk("next_busy", int'(busy), 1);
        chk("next_done", int'(done), 0);
        @(negedge clk);
        chk("done_time", int'(done), 1);
        chk("busy_after", int'(busy), 0);
        repeat (3) @(negedge clk);

        // Parity reference bytes
        wr(0, 8'h07);
        wr(1, 8'h03);
        r0 = rx_cnt;
        go(2, 1'b0);
        wait_done(2 * (FRM + 1) + 10, "par_done");
        repeat (2) @(negedge clk);
        chk("par_rx", rx_cnt - r0, 2);

        // RTS stall before first byte and between bytes
        for (int i = 0; i < 3; i++) wr(i, 8'($urandom));
        rts_n = 1'b1;
        r0 = rx_cnt;
        go(3, 1'b0);
        s0 = stb_cnt;
        err = 0;
        repeat (50) begin
            @(negedge clk);
            if (txd !== 1'b1 || byte_strobe !== 1'b0) err++;
        end
        chk("stall_idle", err, 0);
        chk("stall_busy", int'(busy), 1);
        rts_n = 1'b0;
        wait_stb(5, "stall_release");
        repeat (30) @(negedge clk);
        rts_n = 1'b1;
        wait_rx(r0 + 1, FRM, "midframe_done");
        repeat (40) @(negedge clk);
        chk("mid_stall_stb", stb_cnt - s0, 1);
        chk("mid_stall_txd", int'(txd), 1);
        wr(2, 8'($urandom));
        rts_n = 1'b0;
        wait_done(3 * (FRM + 2) + 10, "stall_done");
        repeat (2) @(negedge clk);
        chk("stall_rx", rx_cnt - r0, 3);

        // Repeat mode, dropped during the third pass
        wr(0, 8'($urandom));
        wr(1, 8'($urandom));
        r0 = rx_cnt;
        d0 = done_cnt;
        go(2, 1'b1);
        wait_rx(r0 + 5, 6 * (FRM + 2), "rep_rx");
        chk("rep_no_done", done_cnt - d0, 0);
        repeat_en = 1'b0;
        wait_done(2 * (FRM + 2) + 10, "rep_done");
        repeat (3) @(negedge clk);
        chk("rep_rx_total", rx_cnt - r0, 6);
        chk("rep_done_cnt", done_cnt - d0, 1);

        // Reset in the middle of data bit 4
        x = 8'($urandom);
        wr(0, x);
        wr(1, 8'($urandom));
        go(2, 1'b0);
        wait_stb(5, "rst_frame_stb");
        repeat (DIV + 4 * DIV + DIV / 2) @(negedge clk);
        chk("pre_rst_bit4", int'(txd), int'(x[4]));
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_txd", int'(txd), 1);
        chk("midrst_busy", int'(busy), 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        r0 = rx_cnt;
        go(1, 1'b0);
        wait_done(FRM + 10, "post_rst_done");
        repeat (2) @(negedge clk);
        chk("post_rst_rx", rx_cnt - r0, 1);

        // Zero length is ignored
        s0 = stb_cnt;
        go(0, 1'b0);
        err = 0;
        repeat (20) begin
            if (busy !== 1'b0) err++;
            @(negedge clk);
        end
        chk("len0_busy", err, 0);
        chk("len0_stb", stb_cnt - s0, 0);

        // Length above DEPTH is clamped; start while busy ignored
        for (int i = 0; i < DEPTH; i++) wr(i, 8'($urandom));
        r0 = rx_cnt;
        s0 = stb_cnt;
        d0 = done_cnt;
        go(12, 1'b0);
        repeat (150) @(negedge clk);
        msg_len = 4'd1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(8 * (FRM + 2) + 10, "clamp_done");
        repeat (3) @(negedge clk);
        chk("clamp_stb", stb_cnt - s0, 8);
        chk("clamp_rx", rx_cnt - r0, 8);
        chk("clamp_done_cnt", done_cnt - d0, 1);

        // Randomized messages with a random initial RTS stall
        for (int t = 0; t < 4; t++) begin
            len = $urandom_range(1, DEPTH);
            for (int i = 0; i < len; i++) wr(i, 8'($urandom));
            st = $urandom_range(0, 20);
            rts_n = 1'b1;
            r0 = rx_cnt;
            s0 = stb_cnt;
            go(len, 1'b0);
            repeat (st) @(negedge clk);
            rts_n = 1'b0;
            wait_done(len * (FRM + 2) + 10, "rnd_done");
            repeat (2) @(negedge clk);
            chk("rnd_rx", rx_cnt - r0, len);
            chk("rnd_stb", stb_cnt - s0, len);
        end

        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
